line_memory: RTL
================

LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 16, meaning line width in bytes; data ports are BLOCK_SIZE*8 bits wide.
REQ-002 SHALL have parameter NUM_LINES, default 256, meaning number of stored lines; power of two.
REQ-003 SHALL have parameter DELAY, default 50, meaning access latency in cycles; legal range >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port is_input_valid  input  1  request strobe.
REQ-007 SHALL have port addr  input  32  line address (byte address already shifted by CLOG2(BLOCK_SIZE)).
REQ-008 SHALL have port mem_read  input  1  read request.
REQ-009 SHALL have port mem_write  input  1  write request.
REQ-010 SHALL have port din  input  BLOCK_SIZE*8  write line data.
REQ-011 SHALL have port mem_ready  output  1  block idle and accepting a request.
REQ-012 SHALL have port is_output_valid  output  1  dout holds freshly read line.
REQ-013 SHALL have port dout  output  BLOCK_SIZE*8  read line data.
REQ-014 SHALL have ports num_reads, num_writes  output  32 each  completed-access counters (see Configuration).

Function
REQ-015 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-016 SHALL drive mem_ready = 1 exactly when the state is IDLE.
REQ-017 SHALL accept a request in IDLE when is_input_valid=1 and exactly one of mem_read/mem_write is 1: latch addr, op, din; load the counter with DELAY-1; go to BUSY.
REQ-018 SHALL ignore, with no state change, any request in IDLE where mem_read and mem_write are both 0 or both 1.
REQ-019 SHALL ignore all inputs while in BUSY; latched values alone determine the access.
REQ-020 SHALL decrement the counter each BUSY cycle; at the edge where counter==0 it completes the access and returns to IDLE.
REQ-021 SHALL, on read completion, load dout with line[addr mod NUM_LINES] and set is_output_valid=1.
REQ-022 SHALL, on write completion, store latched din to line[addr mod NUM_LINES] and leave dout and is_output_valid=0.
REQ-023 SHALL hold is_output_valid high for exactly one cycle (the first IDLE cycle after a read); dout SHALL hold its value until the next read completes.
REQ-024 SHALL give latency: request accepted at edge k, result visible (mem_ready=1, dout valid) after edge k+DELAY; DELAY=1 gives one BUSY cycle.
REQ-025 SHALL accept a new request in the same cycle in which is_output_valid is 1 (back-to-back, no bubble).
REQ-026 SHALL wrap addresses: only the low CLOG2(NUM_LINES) bits of addr select the line; upper bits are ignored.

Reset
REQ-027 SHALL, on reset assertion, asynchronously force state IDLE, counter 0, is_output_valid 0, dout 0, num_reads 0, num_writes 0.
REQ-028 SHALL, on reset during BUSY, abort the access: a pending write is discarded and no line is modified.
REQ-029 SHALL not alter line contents on reset; all lines are zero at time zero only.

Configuration
REQ-030 SHALL, with macro LINE_MEMORY_STATS_EN defined, increment num_reads on each read completion and num_writes on each write completion, wrapping modulo 2^32.
REQ-031 SHALL, without LINE_MEMORY_STATS_EN, tie num_reads and num_writes to constant 0 and instantiate no counter logic.

Verification (DELAY=4, BLOCK_SIZE=16, NUM_LINES=256)
REQ-032 SHALL cover: write addr=0x05 din=0x…DEADBEEF, then read 0x05 -> mem_ready low for 4 cycles each; is_output_valid 1 for one cycle with dout=0x…DEADBEEF.
REQ-033 SHALL cover: mem_read=mem_write=1 with is_input_valid=1 in IDLE -> mem_ready stays 1, no counter or output change.
REQ-034 SHALL cover: write 0x105 data A -> read 0x05 returns A (wrap-around).
REQ-035 SHALL cover: read issued in the cycle is_output_valid=1 -> accepted, next result after 4 more cycles, no idle bubble.
REQ-036 SHALL cover: reset pulsed 2 cycles into a write to 0x07 -> mem_ready=1 immediately, later read of 0x07 returns prior contents (0).
REQ-037 SHALL cover: with LINE_MEMORY_STATS_EN, 3 reads + 2 writes -> num_reads=3, num_writes=2; without the macro both stay 0.

Source files
------------

// File: rtl/line_memory.sv
// line_memory: fixed-latency line-wide backing store with a two-state FSM.
// Optional completed-access counters are built when LINE_MEMORY_STATS_EN is defined.
module line_memory #(
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_LINES  = 256,
   parameter int DELAY      = 50
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    is_input_valid,
   input  logic [31:0]             addr,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [BLOCK_SIZE*8-1:0] din,
   output logic                    mem_ready,
   output logic                    is_output_valid,
   output logic [BLOCK_SIZE*8-1:0] dout,
   output logic [31:0]             num_reads,
   output logic [31:0]             num_writes
);

   localparam int DW = BLOCK_SIZE * 8;
   localparam int AW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [AW-1:0]   r_addr;
   logic            r_wr;
   logic [DW-1:0]   r_din;
   logic [DW-1:0]   r_dout;
   logic            r_ovalid;
   logic            r_ready;

   // Line storage is zero at time zero and deliberately untouched by reset.
   logic [DW-1:0]   r_mem [NUM_LINES] = '{default: '0};

   logic            w_accept;
   logic            w_done;
   logic            w_unused_addr;

   // Only one-hot read/write strobes start an access; the upper address bits wrap away.
   assign w_accept      = is_input_valid && (mem_read ^ mem_write);
   assign w_done        = (r_state == BUSY) && (r_cnt == '0);
   assign w_unused_addr = ^addr[31:AW];

   // Request FSM: latch the request, count down the latency, complete the access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wr     <= 1'b0;
         r_din    <= '0;
         r_dout   <= '0;
         r_ovalid <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         r_ovalid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr  <= addr[AW-1:0];
                  r_wr    <= mem_write;
                  r_din   <= din;
                  r_cnt   <= CW'(DELAY - 1);
                  r_state <= BUSY;
                  r_ready <= 1'b0;
               end
            end
            BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  if (!r_wr) begin
                     r_dout   <= r_mem[r_addr];
                     r_ovalid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Commit a latched write only on its completion edge; an aborted write never lands.
   always_ff @(posedge clk) begin
      if (w_done && r_wr) begin
         r_mem[r_addr] <= r_din;
      end
   end

   assign mem_ready       = r_ready;
   assign is_output_valid = r_ovalid;
   assign dout            = r_dout;

`ifdef LINE_MEMORY_STATS_EN
   logic [31:0] r_num_reads;
   logic [31:0] r_num_writes;

   // Completed-access counters, wrapping modulo 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_num_reads  <= '0;
         r_num_writes <= '0;
      end else if (w_done) begin
         if (r_wr) r_num_writes <= r_num_writes + 32'd1;
         else      r_num_reads  <= r_num_reads + 32'd1;
      end
   end

   assign num_reads  = r_num_reads;
   assign num_writes = r_num_writes;
`else
   assign num_reads  = 32'd0;
   assign num_writes = 32'd0;
`endif

endmodule
